pill_feeder_array: RTL and testbench

//  Multi-channel successor to the single-rate pill pulse source. Drives up to CHANNELS bottle lines with
//  1-cycle pill strobes at a runtime-programmable rate in pills/s, and stops each line after a target count.

---
 rtl/pill_pkg.sv | 18 +
 rtl/pill_feeder_channel.sv | 103 ++++++++++
 rtl/pill_feeder_array.sv | 46 ++++
 tb/tb_pill_feeder_array.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pill_pkg.sv
// Shared types and constants for the pill feeder array.
// The accumulator width is derived here so the channel and any future users agree on it.
package pill_pkg;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_RUN    = 2'd1,
    FEED_PAUSED = 2'd2
  } feed_state_t;

  localparam int CLOCK_HZ_DEFAULT = 100_000_000;

  // Wide enough for acc + rate before the modulus is subtracted.
  function automatic int acc_width(input int clock_hz, input int rate_w);
    return $clog2(clock_hz + (1 << rate_w));
  endfunction

endpackage

// File: rtl/pill_feeder_channel.sv
// One feeder line: start/pause FSM, phase accumulator rate generator and pill counter.
//
// state       | meaning
// ------------+------------------------------------------------------------
// FEED_IDLE   | no run active; count holds last value, done may fire here
// FEED_RUN    | accumulating every cycle, pulses on accumulator wrap
// FEED_PAUSED | held by pause (without strict); acc/count/latched fields frozen
module pill_feeder_channel
  import pill_pkg::*;
#(
  parameter int CLOCK_HZ     = CLOCK_HZ_DEFAULT,
  parameter int RATE_W       = 4,
  parameter int COUNT_W      = 8,
  parameter int DEFAULT_RATE = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic               strict,
  input  logic [RATE_W-1:0]  rate,
  input  logic [COUNT_W-1:0] target,
  output logic               pill_pulse,
  output logic [COUNT_W-1:0] pill_count,
  output logic               busy,
  output logic               done
);

  localparam int                 ACC_W    = acc_width(CLOCK_HZ, RATE_W);
  localparam logic [ACC_W-1:0]   MODULUS  = ACC_W'(CLOCK_HZ);
  localparam logic [RATE_W-1:0]  RATE_SUB = RATE_W'(DEFAULT_RATE);

  feed_state_t        state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_sum;
  logic [RATE_W-1:0]  rate_lat;
  logic [COUNT_W-1:0] target_lat;
  logic [COUNT_W-1:0] count_inc;
  logic               zero_pend;
  logic               hold;
  logic               wrap;
  logic               running;

  always_comb begin
    hold      = pause & ~strict;
    running   = (state != FEED_IDLE);
    acc_sum   = acc + ACC_W'(rate_lat);
    wrap      = (acc_sum >= MODULUS);
    count_inc = pill_count + COUNT_W'(1);
  end

  assign busy = running;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FEED_IDLE;
      acc        <= '0;
      rate_lat   <= '0;
      target_lat <= '0;
      pill_count <= '0;
      pill_pulse <= 1'b0;
      done       <= 1'b0;
      zero_pend  <= 1'b0;
    end else begin
      pill_pulse <= 1'b0;
      done       <= 1'b0;
      zero_pend  <= 1'b0;
      if (start) begin
        rate_lat   <= (rate == '0) ? RATE_SUB : rate;
        target_lat <= target;
        acc        <= '0;
        pill_count <= '0;
        // A zero-length run completes one cycle later without ever leaving IDLE.
        if (target == '0) begin
          state     <= FEED_IDLE;
          zero_pend <= 1'b1;
        end else begin
          state <= FEED_RUN;
        end
      end else if (running) begin
        if (hold) begin
          state <= FEED_PAUSED;
        end else begin
          state <= FEED_RUN;
          if (wrap) begin
            acc        <= acc_sum - MODULUS;
            pill_pulse <= 1'b1;
            pill_count <= count_inc;
            if (count_inc == target_lat) begin
              done  <= 1'b1;
              state <= FEED_IDLE;
            end
          end else begin
            acc <= acc_sum;
          end
        end
      end else begin
        done <= zero_pend;
      end
    end
  end

endmodule

// File: rtl/pill_feeder_array.sv
// CHANNELS independent pill feeder lines sharing only clock and reset.
// Per-channel fields are packed side by side, channel i at the i-th slice.
module pill_feeder_array
  import pill_pkg::*;
#(
  parameter int CLOCK_HZ     = CLOCK_HZ_DEFAULT,
  parameter int CHANNELS     = 2,
  parameter int RATE_W       = 4,
  parameter int COUNT_W      = 8,
  parameter int DEFAULT_RATE = 5
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         start,
  input  logic [CHANNELS-1:0]         pause,
  input  logic [CHANNELS-1:0]         strict,
  input  logic [CHANNELS*RATE_W-1:0]  rate,
  input  logic [CHANNELS*COUNT_W-1:0] target,
  output logic [CHANNELS-1:0]         pill_pulse,
  output logic [CHANNELS*COUNT_W-1:0] pill_count,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pill_feeder_channel #(
      .CLOCK_HZ     (CLOCK_HZ),
      .RATE_W       (RATE_W),
      .COUNT_W      (COUNT_W),
      .DEFAULT_RATE (DEFAULT_RATE)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start[i]),
      .pause      (pause[i]),
      .strict     (strict[i]),
      .rate       (rate[i*RATE_W +: RATE_W]),
      .target     (target[i*COUNT_W +: COUNT_W]),
      .pill_pulse (pill_pulse[i]),
      .pill_count (pill_count[i*COUNT_W +: COUNT_W]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_pill_feeder_array.sv
// Scoreboard bench: each start pushes the pulse/done events predicted from the rate rule
// (pill k lands on the first active cycle n with floor(n*r/CLOCK_HZ) = k); a monitor pops and compares.
module tb_pill_feeder_array;
  localparam int CLK_HZ   = 20;
  localparam int CH       = 2;
  localparam int RW       = 4;
  localparam int CW       = 8;
  localparam int DEF_RATE = 5;
  localparam int NEVER    = 32'h7fff_ffff;

  logic               clock   = 1'b0;
  logic               reset_n = 1'b0;
  logic [CH-1:0]      start   = '0;
  logic [CH-1:0]      pause   = '0;
  logic [CH-1:0]      strict  = '0;
  logic [CH*RW-1:0]   rate    = '0;
  logic [CH*CW-1:0]   target  = '0;
  logic [CH-1:0]      pill_pulse;
  logic [CH*CW-1:0]   pill_count;
  logic [CH-1:0]      busy;
  logic [CH-1:0]      done;

  pill_feeder_array #(
    .CLOCK_HZ(CLK_HZ), .CHANNELS(CH), .RATE_W(RW), .COUNT_W(CW), .DEFAULT_RATE(DEF_RATE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .strict(strict),
    .rate(rate), .target(target), .pill_pulse(pill_pulse), .pill_count(pill_count),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit pulse;
    bit dn;
    int count;
    bit bsy;
  } ev_t;

  ev_t exp_q [CH][$];
  ev_t mev;

  int n_tests = 0;
  int n_fail  = 0;

  // absolute pause/strict windows (edges) and their offsets relative to the next start
  int p_lo[CH], p_hi[CH], s_lo[CH], s_hi[CH];
  int rp_lo[CH], rp_hi[CH], rs_lo[CH], rs_hi[CH];

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic bit hold_at(input int c, input int e);
    return (e >= p_lo[c] && e <= p_hi[c]) && !(e >= s_lo[c] && e <= s_hi[c]);
  endfunction

  // pause/strict levels for the coming edge
  always @(negedge clock) begin
    for (int c = 0; c < CH; c++) begin
      pause[c]  = (cyc + 1 >= p_lo[c]) && (cyc + 1 <= p_hi[c]);
      strict[c] = (cyc + 1 >= s_lo[c]) && (cyc + 1 <= s_hi[c]);
    end
  end

  task automatic push_run(input int c, input int t0, input int r, input int g, input int abort);
    int re, n, k;
    ev_t ev;
    re = (r == 0) ? DEF_RATE : r;
    if (g == 0) begin
      if (t0 + 1 < abort) begin
        ev = '{cyc: t0 + 1, pulse: 1'b0, dn: 1'b1, count: 0, bsy: 1'b0};
        exp_q[c].push_back(ev);
      end
      return;
    end
    n = 0;
    k = 0;
    for (int e = t0 + 1; e < abort && k < g; e++) begin
      if (!hold_at(c, e)) begin
        n++;
        if ((n * re) / CLK_HZ > k) begin
          k++;
          ev = '{cyc: e, pulse: 1'b1, dn: (k == g), count: k, bsy: (k != g)};
          exp_q[c].push_back(ev);
        end
      end
    end
  endtask

  // ab_rel = 0 means the run is not aborted; otherwise events at edges >= t0+ab_rel are dropped
  task automatic start_run(input logic [CH-1:0] m, input int r0, input int g0,
                           input int r1, input int g1, input int ab0, input int ab1,
                           output int t0);
    int rr[CH], gg[CH], ab[CH];
    rr[0] = r0; rr[1] = r1; gg[0] = g0; gg[1] = g1; ab[0] = ab0; ab[1] = ab1;
    t0 = cyc + 1;
    for (int c = 0; c < CH; c++) begin
      if (m[c]) begin
        rate[c*RW +: RW]   = RW'(rr[c]);
        target[c*CW +: CW] = CW'(gg[c]);
        p_lo[c] = t0 + rp_lo[c]; p_hi[c] = t0 + rp_hi[c];
        s_lo[c] = t0 + rs_lo[c]; s_hi[c] = t0 + rs_hi[c];
        push_run(c, t0, rr[c], gg[c], (ab[c] == 0) ? NEVER : t0 + ab[c]);
      end
    end
    start = m;
    @(negedge clock);
    start = '0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && busy == '0) break;
    end
    check("run completes within budget",
          exp_q[0].size() + exp_q[1].size() + int'(busy != '0), 0);
    for (int c = 0; c < CH; c++) exp_q[c].delete();
  endtask

  task automatic no_hold(input int c);
    rp_lo[c] = -100; rp_hi[c] = -100; rs_lo[c] = -100; rs_hi[c] = -100;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " pill_pulse"}, int'(pill_pulse), 0);
    check({name, " pill_count"}, int'(pill_count), 0);
    check({name, " busy"}, int'(busy), 0);
    check({name, " done"}, int'(done), 0);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      for (int c = 0; c < CH; c++) begin
        while (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
          mev = exp_q[c].pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL ch%0d missing event: expected at cycle %0d count %0d, not observed", c, mev.cyc, mev.count);
        end
        if (pill_pulse[c] || done[c]) begin
          if (exp_q[c].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ch%0d unexpected output at cycle %0d: pulse=%0b done=%0b, expected none",
                     c, cyc, pill_pulse[c], done[c]);
          end else begin
            mev = exp_q[c].pop_front();
            check($sformatf("ch%0d event cycle", c), cyc, mev.cyc);
            check($sformatf("ch%0d pill_pulse", c), int'(pill_pulse[c]), int'(mev.pulse));
            check($sformatf("ch%0d done", c), int'(done[c]), int'(mev.dn));
            check($sformatf("ch%0d pill_count", c), int'(pill_count[c*CW +: CW]), mev.count);
            check($sformatf("ch%0d busy", c), int'(busy[c]), int'(mev.bsy));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    int g[CH];
    logic [CH-1:0] m;
    for (int c = 0; c < CH; c++) begin
      no_hold(c);
      p_lo[c] = -100; p_hi[c] = -100; s_lo[c] = -100; s_hi[c] = -100;
    end

    // reset held with start asserted
    reset_n = 1'b0;
    start   = 2'b11;
    rate    = {4'd5, 4'd5};
    target  = {8'd3, 8'd3};
    repeat (3) @(negedge clock);
    check_all_zero("in reset");
    start = '0;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check_all_zero("after reset release");

    // basic run, rate 5 target 3
    start_run(2'b01, 5, 3, 0, 0, 0, 0, t0);
    wait_idle(100);
    check("rate5 final count", int'(pill_count[0 +: CW]), 3);
    check("rate5 busy after done", int'(busy[0]), 0);

    // uneven spacing, rate 3 target 6
    start_run(2'b01, 3, 6, 0, 0, 0, 0, t0);
    wait_idle(100);
    check("rate3 final count", int'(pill_count[0 +: CW]), 6);

    // ch1 paused with a strict override, ch0 running alongside untouched
    rp_lo[1] = 6; rp_hi[1] = 11; rs_lo[1] = 8; rs_hi[1] = 9;
    start_run(2'b11, 5, 4, 5, 4, 0, 0, t0);
    wait_idle(100);
    check("pause ch0 final count", int'(pill_count[0 +: CW]), 4);
    check("pause ch1 final count", int'(pill_count[CW +: CW]), 4);
    no_hold(1);

    // rate 0 uses the default; zero target completes at once
    start_run(2'b11, 0, 2, 7, 0, 0, 0, t0);
    wait_idle(100);
    check("default rate final count", int'(pill_count[0 +: CW]), 2);
    check("zero target count", int'(pill_count[CW +: CW]), 0);

    // restart mid-run, then reset mid-run
    start_run(2'b01, 5, 5, 0, 0, 6, 0, t0);
    repeat (5) @(negedge clock);
    check("before restart count", int'(pill_count[0 +: CW]), 1);
    start_run(2'b01, 5, 5, 0, 0, 6, 0, t1);
    check("restart clears count", int'(pill_count[0 +: CW]), 0);
    check("restart busy", int'(busy[0]), 1);
    repeat (5) @(negedge clock);
    check("before reset count", int'(pill_count[0 +: CW]), 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset mid-run");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    wait_idle(20);
    check("after abort count", int'(pill_count[0 +: CW]), 0);

    // randomized runs on both channels
    for (int it = 0; it < 12; it++) begin
      m = CH'($urandom_range(1, 3));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          rp_lo[c] = $urandom_range(1, 10);
          rp_hi[c] = rp_lo[c] + $urandom_range(0, 8);
          rs_lo[c] = $urandom_range(1, 18);
          rs_hi[c] = rs_lo[c] + $urandom_range(0, 3);
        end else begin
          no_hold(c);
        end
        g[c] = $urandom_range(0, 5);
      end
      start_run(m, $urandom_range(0, 15), g[0], $urandom_range(0, 15), g[1], 0, 0, t0);
      wait_idle(400);
      for (int c = 0; c < CH; c++) begin
        if (m[c]) check($sformatf("random ch%0d final count", c), int'(pill_count[c*CW +: CW]), g[c]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
